// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback-port arbiter: unit indices,
// default widths and the request payload carried through the unit FIFOs.
package wb_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int NUM_UNITS = 3;

  typedef enum logic [1:0] {
    UNIT_X = 2'd0,
    UNIT_Y = 2'd1,
    UNIT_M = 2'd2
  } unit_e;

  typedef struct packed {
    logic [ADDR_W-1:0] regdest;
    logic [DATA_W-1:0] wbvalue;
  } wb_req;

  // Round-robin successor: X -> Y -> M -> X.
  function automatic unit_e next_unit(input unit_e u);
    case (u)
      UNIT_X:  return UNIT_Y;
      UNIT_Y:  return UNIT_M;
      default: return UNIT_X;
    endcase
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the three unit writeback handshakes and the register-file write
// port; the arbiter sits on the slave side, the execution units/RF on master.
interface wb_arbiter_if #(
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int DATA_W = wb_pkg::DATA_W
);

  logic              x_valid;
  logic              x_ready;
  logic [ADDR_W-1:0] x_regdest;
  logic [DATA_W-1:0] x_wbvalue;

  logic              y_valid;
  logic              y_ready;
  logic [ADDR_W-1:0] y_regdest;
  logic [DATA_W-1:0] y_wbvalue;

  logic              m_valid;
  logic              m_ready;
  logic [ADDR_W-1:0] m_regdest;
  logic [DATA_W-1:0] m_wbvalue;

  logic                   wb_reg_en;
  logic [ADDR_W-1:0]      wb_reg_addr;
  logic [DATA_W-1:0]      wb_reg_data;
  logic [2:0]             wb_src;
  logic [2**ADDR_W-1:0]   wb_pending;

  modport slave (
    input  x_valid, x_regdest, x_wbvalue,
    input  y_valid, y_regdest, y_wbvalue,
    input  m_valid, m_regdest, m_wbvalue,
    output x_ready, y_ready, m_ready,
    output wb_reg_en, wb_reg_addr, wb_reg_data, wb_src, wb_pending
  );

  modport master (
    output x_valid, x_regdest, x_wbvalue,
    output y_valid, y_regdest, y_wbvalue,
    output m_valid, m_regdest, m_wbvalue,
    input  x_ready, y_ready, m_ready,
    input  wb_reg_en, wb_reg_addr, wb_reg_data, wb_src, wb_pending
  );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// Per-unit writeback FIFO: DEPTH entries, head output for the arbiter and
// every entry's valid/regdest exposed so the top can build the pending mask.
module wb_fifo #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [ADDR_W-1:0]            push_regdest_i,
  input  logic [DATA_W-1:0]            push_wbvalue_i,
  input  logic                         pop_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [ADDR_W-1:0]            head_regdest_o,
  output logic [DATA_W-1:0]            head_wbvalue_o,
  output logic [DEPTH-1:0]             ent_valid_o,
  output logic [DEPTH-1:0][ADDR_W-1:0] ent_regdest_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] offset;
  logic             do_push, do_pop;

  logic [ADDR_W-1:0] mem_regdest_q [DEPTH];
  logic [DATA_W-1:0] mem_wbvalue_q [DEPTH];

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // A full FIFO never accepts, even when it is popped the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: payload storage is deliberately not reset; ent_valid_o masks stale slots.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_regdest_q[wr_ptr_q] <= push_regdest_i;
      mem_wbvalue_q[wr_ptr_q] <= push_wbvalue_i;
    end
  end

  assign head_regdest_o = mem_regdest_q[rd_ptr_q];
  assign head_wbvalue_o = mem_wbvalue_q[rd_ptr_q];

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    offset        = '0;
    ent_valid_o   = '0;
    ent_regdest_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset           = PTR_W'(i) - rd_ptr_q;
      ent_valid_o[i]   = ({1'b0, offset} < count_q);
      ent_regdest_o[i] = mem_regdest_q[i];
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback-port arbiter: three unit FIFOs drained round-robin, one write per
// cycle, onto a registered register-file port plus a pending-write mask.
module wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int DATA_W = wb_pkg::DATA_W
) (
  input logic         clock,
  input logic         reset,
  wb_arbiter_if.slave bus_if
);

  import wb_pkg::*;

  localparam int NREG = 2**ADDR_W;

  logic [NUM_UNITS-1:0]                         in_valid, in_ready;
  logic [NUM_UNITS-1:0]                         push, pop, full, empty;
  logic [NUM_UNITS-1:0][ADDR_W-1:0]             in_regdest, head_regdest;
  logic [NUM_UNITS-1:0][DATA_W-1:0]             in_wbvalue, head_wbvalue;
  logic [NUM_UNITS-1:0][DEPTH-1:0]              ent_valid;
  logic [NUM_UNITS-1:0][DEPTH-1:0][ADDR_W-1:0]  ent_regdest;

  unit_e                last_q, last_d;
  unit_e                grant_unit, cand;
  logic                 any_grant;
  logic                 wb_en_q, wb_en_d;
  logic [ADDR_W-1:0]    wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]    wb_data_q, wb_data_d;
  logic [NUM_UNITS-1:0] wb_src_q, wb_src_d;
  logic [NREG-1:0]      pending;

  assign in_valid   = {bus_if.m_valid,   bus_if.y_valid,   bus_if.x_valid};
  assign in_regdest = {bus_if.m_regdest, bus_if.y_regdest, bus_if.x_regdest};
  assign in_wbvalue = {bus_if.m_wbvalue, bus_if.y_wbvalue, bus_if.x_wbvalue};

  assign in_ready       = ~full;
  assign bus_if.x_ready = in_ready[UNIT_X];
  assign bus_if.y_ready = in_ready[UNIT_Y];
  assign bus_if.m_ready = in_ready[UNIT_M];

  // Writes to r0 complete the handshake but are dropped before the FIFO.
  always_comb begin
    push = '0;
    for (int u = 0; u < NUM_UNITS; u++)
      push[u] = in_valid[u] & in_ready[u] & (|in_regdest[u]);
  end

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_fifo
    wb_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clock          (clock),
      .reset          (reset),
      .push_i         (push[u]),
      .push_regdest_i (in_regdest[u]),
      .push_wbvalue_i (in_wbvalue[u]),
      .pop_i          (pop[u]),
      .full_o         (full[u]),
      .empty_o        (empty[u]),
      .head_regdest_o (head_regdest[u]),
      .head_wbvalue_o (head_wbvalue[u]),
      .ent_valid_o    (ent_valid[u]),
      .ent_regdest_o  (ent_regdest[u])
    );
  end

  // NOTE: combinational blocks use blocking assignments with every output defaulted first, so no latches.
  always_comb begin
    any_grant  = 1'b0;
    grant_unit = last_q;
    cand       = last_q;
    for (int k = 0; k < NUM_UNITS; k++) begin
      cand = next_unit(cand);
      if (!any_grant && !empty[cand]) begin
        any_grant  = 1'b1;
        grant_unit = cand;
      end
    end
  end

  // Output port and last-grant pointer move only on a grant; addr/data hold when idle.
  always_comb begin
    pop       = '0;
    last_d    = last_q;
    wb_en_d   = any_grant;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    wb_src_d  = '0;
    if (any_grant) begin
      pop[grant_unit]      = 1'b1;
      last_d               = grant_unit;
      wb_addr_d            = head_regdest[grant_unit];
      wb_data_d            = head_wbvalue[grant_unit];
      wb_src_d[grant_unit] = 1'b1;
    end
  end

  // Pointer resets to M so that X is first in line after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q    <= UNIT_M;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_src_q  <= '0;
    end else begin
      last_q    <= last_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      wb_src_q  <= wb_src_d;
    end
  end

  always_comb begin
    pending = '0;
    for (int u = 0; u < NUM_UNITS; u++)
      for (int e = 0; e < DEPTH; e++)
        if (ent_valid[u][e]) pending[ent_regdest[u][e]] = 1'b1;
    if (wb_en_q) pending[wb_addr_q] = 1'b1;
    pending[0] = 1'b0;
  end

  assign bus_if.wb_reg_en   = wb_en_q;
  assign bus_if.wb_reg_addr = wb_addr_q;
  assign bus_if.wb_reg_data = wb_data_q;
  assign bus_if.wb_src      = wb_src_q;
  assign bus_if.wb_pending  = pending;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: per-unit scoreboard queues filled on accepted
// handshakes and drained by a port monitor, plus cycle-exact directed checks.
module tb_wb_arbiter;

  import wb_pkg::*;

  localparam int DEPTH = 2;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  wb_arbiter #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus_if (bus)
  );

  int    vectors     = 0;
  int    miscompares = 0;
  wb_req sb [3][$];
  int    occ [3];
  logic  [2:0] acc_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int u, input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] val);
    case (u)
      0:       begin bus.x_valid = v; bus.x_regdest = rd; bus.x_wbvalue = val; end
      1:       begin bus.y_valid = v; bus.y_regdest = rd; bus.y_wbvalue = val; end
      default: begin bus.m_valid = v; bus.m_regdest = rd; bus.m_wbvalue = val; end
    endcase
  endtask

  task automatic idle_all();
    for (int u = 0; u < 3; u++) drive(u, 1'b0, '0, '0);
  endtask

  function automatic logic get_valid(input int u);
    case (u)
      0: return bus.x_valid;
      1: return bus.y_valid;
      default: return bus.m_valid;
    endcase
  endfunction

  function automatic logic get_ready(input int u);
    case (u)
      0: return bus.x_ready;
      1: return bus.y_ready;
      default: return bus.m_ready;
    endcase
  endfunction

  function automatic wb_req get_req(input int u);
    case (u)
      0: return '{regdest: bus.x_regdest, wbvalue: bus.x_wbvalue};
      1: return '{regdest: bus.y_regdest, wbvalue: bus.y_wbvalue};
      default: return '{regdest: bus.m_regdest, wbvalue: bus.m_wbvalue};
    endcase
  endfunction

  function automatic logic [AW-1:0] rd_for(input int u, input int s);
    return AW'(8 * u + (s % 7) + 1);
  endfunction

  function automatic logic [DW-1:0] val_for(input int u, input int s);
    return DW'((u << 24) | (s << 4) | u);
  endfunction

  // One clock: check ready against the occupancy model, log accepted transfers
  // into the scoreboard, then step past the edge and retire the observed pop.
  task automatic cycle();
    logic [2:0] psh;
    logic       rdy_exp;
    wb_req      r;
    psh = '0;
    @(negedge clock);
    for (int u = 0; u < 3; u++) begin
      rdy_exp = (occ[u] < DEPTH);
      check($sformatf("ready_u%0d", u), get_ready(u), rdy_exp);
      acc_last[u] = get_valid(u) & rdy_exp;
      r = get_req(u);
      if (acc_last[u] && r.regdest != '0) begin
        psh[u] = 1'b1;
        sb[u].push_back(r);
      end
    end
    @(posedge clock);
    #1;
    for (int u = 0; u < 3; u++)
      occ[u] = occ[u] + int'(psh[u]) - int'(bus.wb_src[u]);
  endtask

  task automatic drain(input string tag);
    for (int g = 0; g < 40; g++) begin
      if (sb[0].size() + sb[1].size() + sb[2].size() == 0 && bus.wb_reg_en !== 1'b1) break;
      cycle();
    end
    check({tag, "_sb_empty"}, sb[0].size() + sb[1].size() + sb[2].size(), 0);
    check({tag, "_pending_clear"}, bus.wb_pending, 0);
  endtask

  // Port monitor: every write must be the oldest outstanding entry of its unit.
  always @(negedge clock) begin : mon
    int    u;
    wb_req e;
    if (reset === 1'b1 && bus.wb_reg_en === 1'b1) begin
      case (bus.wb_src)
        3'b001:  u = 0;
        3'b010:  u = 1;
        3'b100:  u = 2;
        default: u = -1;
      endcase
      check("mon_src_onehot", u >= 0, 1'b1);
      if (u >= 0) begin
        check($sformatf("mon_sb_nonempty_u%0d", u), sb[u].size() > 0, 1'b1);
        if (sb[u].size() > 0) begin
          e = sb[u].pop_front();
          check($sformatf("mon_addr_u%0d", u), bus.wb_reg_addr, e.regdest);
          check($sformatf("mon_data_u%0d", u), bus.wb_reg_data, e.wbvalue);
        end
        check("mon_pending_port", bus.wb_pending[bus.wb_reg_addr], 1'b1);
      end
    end else if (reset === 1'b1) begin
      check("mon_idle_src", bus.wb_src, 0);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq [3];
    int gcnt [3];
    int last_g [3];
    int maxw;
    int y_full_cycles;
    logic y_was_full;
    logic y_pop_seen;

    idle_all();
    for (int u = 0; u < 3; u++) occ[u] = 0;
    acc_last = '0;

    // Reset state
    #2;
    check("rst_en", bus.wb_reg_en, 0);
    check("rst_addr", bus.wb_reg_addr, 0);
    check("rst_data", bus.wb_reg_data, 0);
    check("rst_src", bus.wb_src, 0);
    check("rst_pending", bus.wb_pending, 0);
    check("rst_ready", {bus.m_ready, bus.y_ready, bus.x_ready}, 3'b111);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;

    // Simultaneous push from all units: X first after reset, then Y, then M
    drive(0, 1'b1, 5'd1, 32'h1111_0001);
    drive(1, 1'b1, 5'd2, 32'h2222_0002);
    drive(2, 1'b1, 5'd3, 32'h3333_0003);
    cycle();
    idle_all();
    check("tri_en_after_push", bus.wb_reg_en, 0);
    check("tri_pending_queued", bus.wb_pending, 32'h0000_000E);
    cycle();
    check("tri1_en", bus.wb_reg_en, 1);
    check("tri1_addr", bus.wb_reg_addr, 1);
    check("tri1_src", bus.wb_src, 3'b001);
    cycle();
    check("tri2_addr", bus.wb_reg_addr, 2);
    check("tri2_src", bus.wb_src, 3'b010);
    cycle();
    check("tri3_addr", bus.wb_reg_addr, 3);
    check("tri3_src", bus.wb_src, 3'b100);
    check("tri3_pending", bus.wb_pending, 32'h0000_0008);
    cycle();
    check("tri_idle_en", bus.wb_reg_en, 0);
    check("tri_idle_addr_hold", bus.wb_reg_addr, 3);
    check("tri_idle_data_hold", bus.wb_reg_data, 32'h3333_0003);
    check("tri_idle_pending", bus.wb_pending, 0);

    // Single X push: visible in the mask next cycle, on the port one edge later
    drive(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    cycle();
    idle_all();
    check("single_en_after_push", bus.wb_reg_en, 0);
    check("single_pending_queued", bus.wb_pending, 32'h0000_0020);
    cycle();
    check("single_en", bus.wb_reg_en, 1);
    check("single_addr", bus.wb_reg_addr, 5);
    check("single_data", bus.wb_reg_data, 32'hDEAD_BEEF);
    check("single_src", bus.wb_src, 3'b001);
    check("single_pending_port", bus.wb_pending, 32'h0000_0020);
    cycle();
    check("single_done_en", bus.wb_reg_en, 0);
    check("single_done_pending", bus.wb_pending, 0);

    // All units saturated for 30 cycles: equal share, bounded wait
    for (int u = 0; u < 3; u++) begin
      seq[u] = 0;
      gcnt[u] = 0;
      last_g[u] = -1;
      drive(u, 1'b1, rd_for(u, 0), val_for(u, 0));
    end
    maxw = 0;
    cycle();
    for (int c = 0; c < 30; c++) begin
      for (int u = 0; u < 3; u++)
        if (acc_last[u]) begin
          seq[u]++;
          drive(u, 1'b1, rd_for(u, seq[u]), val_for(u, seq[u]));
        end
      cycle();
      for (int u = 0; u < 3; u++)
        if (bus.wb_src[u]) begin
          gcnt[u]++;
          if (last_g[u] >= 0 && c - last_g[u] - 1 > maxw) maxw = c - last_g[u] - 1;
          last_g[u] = c;
        end
    end
    idle_all();
    check("sat_grants_x", gcnt[0], 10);
    check("sat_grants_y", gcnt[1], 10);
    check("sat_grants_m", gcnt[2], 10);
    check("sat_max_wait_le2", maxw <= 2, 1'b1);
    drain("sat");

    // Y fills up behind X/M traffic; ready drops while full and recovers after a pop
    for (int u = 0; u < 3; u++) seq[u] = 100;
    drive(0, 1'b1, rd_for(0, seq[0]), val_for(0, seq[0]));
    drive(2, 1'b1, rd_for(2, seq[2]), val_for(2, seq[2]));
    cycle();
    drive(1, 1'b1, rd_for(1, seq[1]), val_for(1, seq[1]));
    y_full_cycles = 0;
    y_pop_seen = 1'b0;
    for (int c = 0; c < 14; c++) begin
      for (int u = 0; u < 3; u++)
        if (acc_last[u] && get_valid(u)) begin
          seq[u]++;
          drive(u, 1'b1, rd_for(u, seq[u]), val_for(u, seq[u]));
        end
      y_was_full = (occ[1] == DEPTH);
      if (y_was_full) y_full_cycles++;
      cycle();
      if (y_was_full && bus.wb_src[1] && !y_pop_seen) begin
        y_pop_seen = 1'b1;
        check("yfill_ready_after_pop", bus.y_ready, 1'b1);
      end
    end
    idle_all();
    check("yfill_full_reached", y_full_cycles > 0, 1'b1);
    check("yfill_pop_from_full", y_pop_seen, 1'b1);
    drain("yfill");

    // M write to r0: handshake completes but nothing reaches the port
    drive(2, 1'b1, 5'd0, 32'h0BAD_F00D);
    cycle();
    idle_all();
    check("r0_pending_after", bus.wb_pending, 0);
    for (int c = 0; c < 3; c++) begin
      cycle();
      check($sformatf("r0_no_write_%0d", c), bus.wb_reg_en, 0);
      check($sformatf("r0_pending_%0d", c), bus.wb_pending, 0);
    end

    // Reset mid-operation with four writes outstanding
    drive(0, 1'b1, 5'd10, 32'hA000_000A);
    drive(1, 1'b1, 5'd11, 32'hB000_000B);
    cycle();
    drive(0, 1'b1, 5'd12, 32'hA000_000C);
    drive(1, 1'b0, 5'd0, 32'h0);
    drive(2, 1'b1, 5'd13, 32'hC000_000D);
    cycle();
    idle_all();
    check("midrst_pending_before", bus.wb_pending, 32'h0000_3C00);
    check("midrst_en_before", bus.wb_reg_en, 1);
    #2 reset = 1'b0;
    #1;
    check("midrst_en_async", bus.wb_reg_en, 0);
    check("midrst_src_async", bus.wb_src, 0);
    check("midrst_pending_async", bus.wb_pending, 0);
    for (int u = 0; u < 3; u++) begin
      sb[u].delete();
      occ[u] = 0;
    end
    @(posedge clock);
    #1 reset = 1'b1;
    check("postrst_ready", {bus.m_ready, bus.y_ready, bus.x_ready}, 3'b111);
    check("postrst_pending", bus.wb_pending, 0);
    check("postrst_en", bus.wb_reg_en, 0);
    drive(0, 1'b1, 5'd20, 32'h0000_0020);
    drive(1, 1'b1, 5'd21, 32'h0000_0021);
    cycle();
    idle_all();
    cycle();
    check("postrst_first_src", bus.wb_src, 3'b001);
    check("postrst_first_addr", bus.wb_reg_addr, 20);
    cycle();
    check("postrst_second_src", bus.wb_src, 3'b010);
    check("postrst_second_addr", bus.wb_reg_addr, 21);
    drain("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
